accelerator_mac_pipe: RTL and testbench

- Parametrised pipelined successor to the single-cycle signed multiplier cores used by the accelerator datapath.
- Adds a configurable register depth, a per-transaction signed/unsigned mode, and an optional accumulator with a sticky overflow flag.
- Uses valid/ready handshakes with whole-pipe stall on backpressure.
- Sits between the HLS-scheduled operand fetch and the result write-back for dot-product and XOR-layer kernels.

---
 rtl/accelerator_mac_pipe.sv | 199 +++++++++++++++++++
 tb/tb_accelerator_mac_pipe.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accelerator_mac_pipe.sv
// accelerator_mac_pipe: pipelined signed/unsigned multiplier with optional
// accumulator and sticky overflow, valid/ready handshakes, whole-pipe stall.
// Ports: clk, reset (async, active high), ce (clock enable),
//   in_valid/in_ready + din0, din1, op_signed, acc_en, acc_clr (operand side),
//   out_valid/out_ready + dout, ovf (result side).
module accelerator_mac_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  op_signed,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int W0 = din0_WIDTH;
  localparam int W1 = din1_WIDTH;
  localparam int DW = dout_WIDTH;

  if (DW < W0 + W1) begin : g_bad_width
    $error("dout_WIDTH must be >= din0_WIDTH + din1_WIDTH");
  end

  if (NUM_STAGE < 1 || NUM_STAGE > 6 || ID < 0) begin : g_bad_stage
    $error("NUM_STAGE must be 1..6 and ID non-negative");
  end

  typedef struct packed {
    logic          valid;
    logic          sgn;
    logic          acc_en;
    logic          acc_clr;
    logic [W0-1:0] a;
    logic [W1-1:0] b;
  } op_t;

  typedef struct packed {
    logic          valid;
    logic          sgn;
    logic          acc_en;
    logic          acc_clr;
    logic [DW-1:0] prod;
  } pr_t;

  // Operands are widened to the result width first, so the
  // truncated product is exact in both signed and unsigned mode.
  function automatic pr_t mul(input op_t o);
    logic [DW-1:0] ax;
    logic [DW-1:0] bx;
    pr_t           r;
    ax        = {{(DW-W0){o.sgn & o.a[W0-1]}}, o.a};
    bx        = {{(DW-W1){o.sgn & o.b[W1-1]}}, o.b};
    r.valid   = o.valid;
    r.sgn     = o.sgn;
    r.acc_en  = o.acc_en;
    r.acc_clr = o.acc_clr;
    r.prod    = ax * bx;
    return r;
  endfunction

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          ovf_q, ovf_d;

  logic stall;
  logic adv;

  assign stall    = (out_valid_q & ~out_ready) | ~ce;
  assign adv      = ~stall;
  assign in_ready = adv;

  op_t op_in;
  op_t op_mul;
  pr_t pr_mul;
  pr_t fin;

  assign op_in = '{
    valid:   in_valid,
    sgn:     op_signed,
    acc_en:  acc_en,
    acc_clr: acc_clr,
    a:       din0,
    b:       din1
  };

  assign pr_mul = mul(op_mul);

  if (NUM_STAGE == 1) begin : g_one
    assign op_mul = op_in;
    assign fin    = pr_mul;
  end else begin : g_multi
    op_t s1_q, s1_d;

    always_comb begin
      s1_d = s1_q;
      if (adv) s1_d = op_in;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) s1_q <= '0;
      else       s1_q <= s1_d;
    end

    assign op_mul = s1_q;

    if (NUM_STAGE == 2) begin : g_direct
      assign fin = pr_mul;
    end else begin : g_mid
      pr_t mid_q [NUM_STAGE-2];
      pr_t mid_d [NUM_STAGE-2];

      always_comb begin
        mid_d = mid_q;
        if (adv) begin
          mid_d[0] = pr_mul;
          for (int i = 1; i < NUM_STAGE - 2; i++)
            mid_d[i] = mid_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < NUM_STAGE - 2; i++)
            mid_q[i] <= '0;
        end else begin
          mid_q <= mid_d;
        end
      end

      assign fin = mid_q[NUM_STAGE-3];
    end
  end

  // Extra top bit captures the unsigned carry-out.
  logic [DW:0] sum;

  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    sum         = {1'b0, acc_q} + {1'b0, fin.prod};
    if (adv) begin
      out_valid_d = fin.valid;
      if (fin.valid) begin
        if (!fin.acc_en) begin
          dout_d = fin.prod;
        end else if (fin.acc_clr) begin
          acc_d  = fin.prod;
          dout_d = fin.prod;
          ovf_d  = 1'b0;
        end else begin
          acc_d  = sum[DW-1:0];
          dout_d = sum[DW-1:0];
          if (fin.sgn) begin
            if ((acc_q[DW-1] == fin.prod[DW-1]) &&
                (sum[DW-1] != acc_q[DW-1]))
              ovf_d = 1'b1;
          end else if (sum[DW]) begin
            ovf_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_accelerator_mac_pipe.sv
// tb_accelerator_mac_pipe: scoreboard bench for accelerator_mac_pipe,
// two instances (48-bit and 42-bit result) sharing one stimulus stream.
module tb_accelerator_mac_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic [31:0] din0;
  logic [9:0]  din1;
  logic        op_signed;
  logic        acc_en;
  logic        acc_clr;
  logic        out_ready;

  logic        in_ready, out_valid, ovf;
  logic [47:0] dout;
  logic        in_ready2, out_valid2, ovf2;
  logic [41:0] dout2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint d;
    bit     ov;
  } exp_t;

  exp_t   q1[$];
  exp_t   q2[$];
  longint acc1, acc2;
  bit     ov1, ov2;
  bit     rand_bp = 1'b0;

  always #5 clk = ~clk;

  accelerator_mac_pipe #(
    .ID(1), .NUM_STAGE(2), .din0_WIDTH(32),
    .din1_WIDTH(10), .dout_WIDTH(48)
  ) u_dut (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1),
    .op_signed(op_signed), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .ovf(ovf)
  );

  accelerator_mac_pipe #(
    .ID(2), .NUM_STAGE(2), .din0_WIDTH(32),
    .din1_WIDTH(10), .dout_WIDTH(42)
  ) u_dut42 (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready2),
    .din0(din0), .din1(din1),
    .op_signed(op_signed), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid2), .out_ready(out_ready),
    .dout(dout2), .ovf(ovf2)
  );

  // Reference: exact integer arithmetic, overflow judged by
  // whether the true sum leaves the representable range.
  function automatic void ref_mac(
    input  int          dw,
    input  logic [31:0] a,
    input  logic [9:0]  b,
    input  bit          sg,
    input  bit          en,
    input  bit          clr,
    inout  longint      acc,
    inout  bit          ov,
    output longint      res
  );
    longint mask, lim, pa, pb, p, sa, sp, s;
    mask = (longint'(1) <<< dw) - 1;
    lim  = longint'(1) <<< (dw - 1);
    pa   = sg ? longint'($signed(a)) : longint'({32'd0, a});
    pb   = sg ? longint'($signed(b)) : longint'({54'd0, b});
    p    = (pa * pb) & mask;
    if (!en) begin
      res = p;
    end else if (clr) begin
      acc = p;
      ov  = 1'b0;
      res = p;
    end else begin
      if (sg) begin
        sa = ((acc & lim) != 0) ? (acc | ~mask) : acc;
        sp = ((p & lim) != 0) ? (p | ~mask) : p;
        s  = sa + sp;
        if (s >= lim || s < -lim) ov = 1'b1;
      end else begin
        s = acc + p;
        if (s > mask) ov = 1'b1;
      end
      acc = s & mask;
      res = acc;
    end
  endfunction

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called right after a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [31:0] a, input logic [9:0] b,
                      input bit sg, input bit en, input bit clr);
    int     n;
    longint r;
    exp_t   e;
    n         = 0;
    din0      = a;
    din1      = b;
    op_signed = sg;
    acc_en    = en;
    acc_clr   = clr;
    in_valid  = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!in_ready || in_ready2 !== in_ready) begin
      errors++;
      $display("FAIL accept: in_ready %b in_ready42 %b expected 1",
               in_ready, in_ready2);
    end else begin
      ref_mac(48, a, b, sg, en, clr, acc1, ov1, r);
      e.d  = r;
      e.ov = ov1;
      q1.push_back(e);
      ref_mac(42, a, b, sg, en, clr, acc2, ov2, r);
      e.d  = r;
      e.ov = ov2;
      q2.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain: pending %0d/%0d expected 0/0",
               q1.size(), q2.size());
    end
    @(negedge clk);
  endtask

  // Monitor: an output shown with out_ready & ce retires at the next edge.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && ce && out_ready) begin
        if (out_valid) begin
          if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out48: got %0h expected no output", dout);
          end else begin
            e = q1.pop_front();
            chk("dout48", longint'(dout), e.d);
            chk("ovf48", longint'(ovf), longint'(e.ov));
          end
        end
        if (out_valid2) begin
          if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out42: got %0h expected no output", dout2);
          end else begin
            e = q2.pop_front();
            chk("dout42", longint'(dout2), e.d);
            chk("ovf42", longint'(ovf2), longint'(e.ov));
          end
        end
      end
    end
  end

  initial begin : bp
    forever begin
      @(negedge clk);
      if (rand_bp) begin
        out_ready = ($urandom_range(0, 3) != 0);
        ce        = ($urandom_range(0, 7) != 0);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic model_reset();
    acc1 = 0;
    acc2 = 0;
    ov1  = 1'b0;
    ov2  = 1'b0;
    q1.delete();
    q2.delete();
  endtask

  initial begin : main
    logic [47:0] hold;
    logic [31:0] ra;
    logic [9:0]  rb;
    bit          sg, en;
    int          len, t;

    reset     = 1'b1;
    ce        = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    din0      = '0;
    din1      = '0;
    op_signed = 1'b0;
    acc_en    = 1'b0;
    acc_clr   = 1'b0;
    model_reset();
    #2;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_dout", longint'(dout), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Latency and signed product
    send(-32'sd3, 10'd7, 1, 0, 0);
    chk("lat_early", longint'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_valid", longint'(out_valid), 1);
    chk("neg21", longint'(dout), longint'(48'hFFFF_FFFF_FFEB));
    @(negedge clk);
    drain();

    // Unsigned vs signed interpretation of the same bits
    send(32'hFFFF_FFFF, 10'h3FF, 0, 0, 0);
    send(32'hFFFF_FFFF, 10'h3FF, 1, 0, 0);
    // Back-to-back accumulation
    send(32'd2, 10'd3, 1, 1, 1);
    send(32'd4, 10'd5, 1, 1, 0);
    send(-32'sd1, 10'd6, 1, 1, 0);
    send(32'd10, 10'd10, 1, 1, 0);
    drain();

    // Unsigned carry out on the 42-bit instance
    send(32'hFFFF_FFFF, 10'h3FF, 0, 1, 1);
    send(32'hFFFF_FFFF, 10'h3FF, 0, 1, 0);
    drain();
    chk("ucarry_ovf42", longint'(ovf2), 1);
    chk("ucarry_ovf48", longint'(ovf), 0);
    send(32'd1, 10'd1, 0, 1, 1);
    drain();
    chk("clr_ovf42", longint'(ovf2), 0);

    // Signed overflow: three large positive products
    send(32'h7FFF_FFFF, 10'h1FF, 1, 1, 1);
    send(32'h7FFF_FFFF, 10'h1FF, 1, 1, 0);
    send(32'h7FFF_FFFF, 10'h1FF, 1, 1, 0);
    drain();
    chk("sovf42", longint'(ovf2), 1);
    chk("sovf_neg42", longint'(dout2[41]), 1);
    chk("sovf48", longint'(ovf), 0);

    // Reset mid-flight with two transactions in the pipe
    out_ready = 1'b0;
    send(32'd5, 10'd5, 0, 0, 0);
    send(32'd6, 10'd6, 0, 0, 0);
    #3;
    reset = 1'b1;
    #1;
    chk("mrst_out_valid", longint'(out_valid), 0);
    chk("mrst_out_valid42", longint'(out_valid2), 0);
    chk("mrst_dout", longint'(dout), 0);
    chk("mrst_ovf42", longint'(ovf2), 0);
    model_reset();
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    send(32'd9, 10'd9, 1, 0, 0);
    drain();

    // Backpressure with continuous input
    fork
      begin
        for (int k = 0; k < 6; k++)
          send($urandom, 10'($urandom), 1, 1, k == 0);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        hold = dout;
        chk("bp_valid", longint'(out_valid), 1);
        chk("bp_in_ready", longint'(in_ready), 0);
        repeat (2) begin
          @(negedge clk);
          #1;
          chk("bp_dout_hold", longint'(dout), longint'(hold));
          chk("bp_in_ready", longint'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Randomised bursts with random backpressure and clock enable
    rand_bp = 1'b1;
    t = 0;
    while (t < 300) begin
      sg  = 1'($urandom_range(0, 1));
      en  = 1'($urandom_range(0, 2) != 0);
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 5))
          0:       ra = 32'h7FFF_FFFF;
          1:       ra = 32'h8000_0000;
          2:       ra = 32'hFFFF_FFFF;
          default: ra = $urandom;
        endcase
        case ($urandom_range(0, 4))
          0:       rb = 10'h1FF;
          1:       rb = 10'h200;
          2:       rb = 10'h3FF;
          default: rb = 10'($urandom);
        endcase
        send(ra, rb, sg, en, k == 0);
        t++;
      end
    end
    rand_bp   = 1'b0;
    out_ready = 1'b1;
    ce        = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
